// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
//
// Purpose: defaults shared by the UART receive path (character width,
// receive FIFO depth) and the receiver FSM state encoding.
// Ports: none (package).
package uart_pkg;

  localparam int DBIT_DEFAULT   = 8;  // data bits per character
  localparam int ADDR_W_DEFAULT = 4;  // log2 of receive FIFO depth

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - dual-port register array for the UART receive FIFO
//
// Purpose: 2**ADDR_W x DBIT storage, synchronous write, asynchronous read,
// cleared on reset so the read port shows 0 out of reset.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset, clears all entries
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr    in   read address
//   rdata    out  combinational read data
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DBIT   = DBIT_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DBIT-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DBIT-1:0]   rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DBIT-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO between UART receiver and consumer stream
//
// Purpose: captures each byte on rx_done_tick into a circular FIFO and
// presents it first-word-fall-through on a valid/ready stream. Reports
// fill level, full/empty and a sticky overrun for bytes dropped when full.
// Optional macro UART_RX_FIFO_WATERMARK_EN enables the registered
// almost_full = (level >= AF_LEVEL) flag; otherwise almost_full is tied 0.
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   rx_done_tick  in   one-cycle strobe, rx_dout holds a complete byte
//   rx_dout       in   received byte
//   m_data        out  head-of-FIFO byte
//   m_valid       out  FIFO non-empty
//   m_ready       in   consumer accepts m_data this cycle
//   level         out  number of stored bytes, 0..2**ADDR_W
//   full          out  level == 2**ADDR_W
//   empty         out  level == 0
//   overrun       out  sticky dropped-byte flag
//   clr_overrun   in   one-cycle clear of overrun
//   almost_full   out  watermark flag
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT     = DBIT_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int AF_LEVEL = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_dout,
  output logic [DBIT-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [ADDR_W:0] level,
  output logic            full,
  output logic            empty,
  output logic            overrun,
  input  logic            clr_overrun,
  output logic            almost_full
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            push;
  logic            pop;
  logic            drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign m_valid = !empty;

  assign pop  = m_valid && m_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push = rx_done_tick && (!full || pop);
  assign drop = rx_done_tick && full && !pop;

  uart_fifo_mem #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (push),
    .waddr   (wr_ptr[ADDR_W-1:0]),
    .wdata   (rx_dout),
    .raddr   (rd_ptr[ADDR_W-1:0]),
    .rdata   (m_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Set has priority over clear so a drop coinciding with a clear is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_WATERMARK_EN
  localparam logic [ADDR_W:0] AF_THR = (ADDR_W + 1)'(AF_LEVEL);

  logic [ADDR_W:0] level_next;
  logic            af_q;

  // Registering the compare on the next level keeps almost_full aligned
  // with level on the same edge.
  always_comb begin
    level_next = level;
    if (push && !pop) level_next = level + PTR_ONE;
    if (pop && !push) level_next = level - PTR_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (level_next >= AF_THR);
    end
  end

  assign almost_full = af_q;
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_done_tick;
  logic [7:0] rx_dout;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       overrun;
  logic       clr_overrun;
  logic       almost_full;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DBIT     (8),
    .ADDR_W   (4),
    .AF_LEVEL (12)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun),
    .almost_full  (almost_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      rx_done_tick = 1'b1;
      rx_dout      = base + 8'(i);
      tick();
    end
    rx_done_tick = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!m_valid) break;
      tick();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rx_done_tick = 1'b0; rx_dout = 8'h00;
    m_ready = 1'b0; clr_overrun = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || m_valid !== 1'b0 ||
        overrun !== 1'b0 || almost_full !== 1'b0 || m_data !== 8'h00) begin
      failures++;
      $display("FAIL reset: level=%0d empty=%b full=%b m_valid=%b overrun=%b af=%b m_data=%h required 0 1 0 0 0 0 00",
               level, empty, full, m_valid, overrun, almost_full, m_data);
    end
  endtask

  task automatic test_single_byte();
    rx_done_tick = 1'b1; rx_dout = 8'hA5;
    tick();
    rx_done_tick = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || level !== 5'd1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL single_push: m_valid=%b m_data=%h level=%0d empty=%b required 1 a5 1 0",
               m_valid, m_data, level, empty);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (m_data !== 8'hA5 || m_valid !== 1'b1) begin
        failures++;
        $display("FAIL single_hold[%0d]: m_data=%h m_valid=%b required a5 1", i, m_data, m_valid);
      end
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || level !== 5'd0) begin
      failures++;
      $display("FAIL single_pop: empty=%b level=%0d required 1 0", empty, level);
    end
  endtask

  task automatic test_fill_overrun();
    push_n(8'h00, 16);
    checks++;
    if (full !== 1'b1 || level !== 5'd16) begin
      failures++;
      $display("FAIL fill_full: full=%b level=%0d required 1 16", full, level);
    end
    rx_done_tick = 1'b1; rx_dout = 8'hFF;
    tick();
    rx_done_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1 || level !== 5'd16) begin
      failures++;
      $display("FAIL fill_overrun: overrun=%b level=%0d required 1 16", overrun, level);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        failures++;
        $display("FAIL fill_drain[%0d]: m_valid=%b m_data=%h required 1 %h", i, m_valid, m_data, 8'(i));
      end
      tick();
    end
    m_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_empty: empty=%b m_valid=%b required 1 0", empty, m_valid);
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL fill_clear: overrun=%b required 0", overrun);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    push_n(8'h10, 16);
    m_ready = 1'b1; rx_done_tick = 1'b1; rx_dout = 8'h55;
    tick();
    rx_done_tick = 1'b0; m_ready = 1'b0;
    checks++;
    if (level !== 5'd16 || overrun !== 1'b0 || full !== 1'b1) begin
      failures++;
      $display("FAIL pushpop_full: level=%0d overrun=%b full=%b required 16 0 1", level, overrun, full);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'(8'h11 + i) : 8'h55;
      checks++;
      if (m_data !== exp) begin
        failures++;
        $display("FAIL pushpop_drain[%0d]: m_data=%h required %h", i, m_data, exp);
      end
      tick();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_overrun_race();
    push_n(8'h20, 16);
    rx_done_tick = 1'b1; rx_dout = 8'h77; clr_overrun = 1'b1;
    tick();
    rx_done_tick = 1'b0; clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL race_set_wins: overrun=%b required 1", overrun);
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL race_clear: overrun=%b required 0", overrun);
    end
    drain();
  endtask

  task automatic test_wrap();
    logic [7:0] sb[$];
    int   model_level = 0;
    int   pushed = 0;
    int   popped = 0;
    int   cyc = 0;
    logic do_pop;
    logic do_push;
    while (popped < 40 && cyc < 2000) begin
      do_push      = (pushed < 40) && ($urandom_range(0, 3) != 0);
      m_ready      = ($urandom_range(0, 2) != 0);
      rx_done_tick = do_push;
      rx_dout      = 8'(8'h80 + pushed);
      do_pop       = m_ready && (model_level > 0);
      if (do_pop) begin
        checks++;
        if (m_data !== sb[0]) begin
          failures++;
          $display("FAIL wrap_data[%0d]: m_data=%h required %h", popped, m_data, sb[0]);
        end
      end
      tick();
      if (do_pop) begin
        void'(sb.pop_front());
        model_level--;
        popped++;
      end
      if (do_push && model_level < 16) begin
        sb.push_back(8'(8'h80 + pushed));
        model_level++;
        pushed++;
      end
      checks++;
      if (level !== 5'(model_level) || model_level > 16 || model_level < 0) begin
        failures++;
        $display("FAIL wrap_level: level=%0d required %0d", level, model_level);
      end
      cyc++;
    end
    rx_done_tick = 1'b0; m_ready = 1'b0;
    checks++;
    if (popped != 40) begin
      failures++;
      $display("FAIL wrap_timeout: popped=%0d required 40", popped);
    end
  endtask

  task automatic test_reset_midstream();
    push_n(8'h40, 7);
    checks++;
    if (level !== 5'd7) begin
      failures++;
      $display("FAIL mid_prefill: level=%0d required 7", level);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset: level=%0d empty=%b overrun=%b m_valid=%b m_data=%h required 0 1 0 0 00",
               level, empty, overrun, m_valid, m_data);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_watermark();
`ifdef UART_RX_FIFO_WATERMARK_EN
    push_n(8'h60, 11);
    checks++;
    if (almost_full !== 1'b0) begin
      failures++;
      $display("FAIL wm_below: almost_full=%b required 0", almost_full);
    end
    push_n(8'h6B, 1);
    checks++;
    if (almost_full !== 1'b1) begin
      failures++;
      $display("FAIL wm_rise: almost_full=%b required 1", almost_full);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if (almost_full !== 1'b0 || level !== 5'd11) begin
      failures++;
      $display("FAIL wm_fall: almost_full=%b level=%0d required 0 11", almost_full, level);
    end
`else
    push_n(8'h60, 16);
    checks++;
    if (almost_full !== 1'b0 || full !== 1'b1) begin
      failures++;
      $display("FAIL wm_tied: almost_full=%b full=%b required 0 1", almost_full, full);
    end
`endif
    drain();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_overrun();
    test_full_push_pop();
    test_overrun_race();
    test_wrap();
    test_reset_midstream();
    test_watermark();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
